wb_mem_rr_arbiter: RTL and testbench

WB_MEM_RR_ARBITER -- requirements
Module: wb_mem_rr_arbiter

---
 rtl/wb_mem_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_mem_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port.
// Grant is registered (one cycle latency), held for the whole cyc of the
// granted master, and a watchdog errors out beats the slave never answers.
module wb_mem_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    // master side, slice i belongs to master i
    input  logic [AW*NUM_MASTERS-1:0]   wbm_adr_i,
    input  logic [DW*NUM_MASTERS-1:0]   wbm_dat_i,
    input  logic [DW/8*NUM_MASTERS-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [3*NUM_MASTERS-1:0]    wbm_cti_i,
    input  logic [2*NUM_MASTERS-1:0]    wbm_bte_i,
    output logic [DW*NUM_MASTERS-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    // slave side
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    // status
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
    localparam logic [NUM_MASTERS-1:0] GNT_ONE = NUM_MASTERS'(1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          r_last;
    logic [7:0]             r_wdog;

    logic [IW-1:0] w_pick, w_cand, w_sel;
    logic          w_any, w_busy, w_gcyc, w_gstb, w_resp, w_tmo;

    assign w_busy = (r_state == S_BUSY);
    // idle cycles park the slave mux on slice 0
    assign w_sel  = w_busy ? r_idx : '0;
    assign w_gcyc = wbm_cyc_i[w_sel];
    assign w_gstb = wbm_stb_i[w_sel];
    assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // a real slave response in the same cycle beats the watchdog
    assign w_tmo  = w_busy && w_gstb && !w_resp && (r_wdog == TO_CNT);

    // round-robin search starting one past the last served master
    always_comb begin
        w_pick = '0;
        w_cand = '0;
        w_any  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_cand = IW'((int'(r_last) + k) % NUM_MASTERS);
            if (!w_any && wbm_cyc_i[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    // next-state: grant on any request, release when the owner drops cyc
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)   w_state_nxt = S_BUSY;
            S_BUSY:  if (!w_gcyc) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state, grant and round-robin pointer registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            if (!w_busy && w_any) begin
                r_grant <= GNT_ONE << w_pick;
                r_idx   <= w_pick;
            end else if (w_busy && !w_gcyc) begin
                r_grant <= '0;
                r_last  <= r_idx;
            end
        end
    end

    // watchdog: counts stalled beats, restarts on any response or gap
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !w_busy || w_tmo || !w_gstb || w_resp)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + 8'd1;
    end

    // slave-side request mux
    always_comb begin
        wbs_adr_o = wbm_adr_i[int'(w_sel)*AW +: AW];
        wbs_dat_o = wbm_dat_i[int'(w_sel)*DW +: DW];
        wbs_sel_o = wbm_sel_i[int'(w_sel)*SW +: SW];
        wbs_cti_o = wbm_cti_i[int'(w_sel)*3 +: 3];
        wbs_bte_o = wbm_bte_i[int'(w_sel)*2 +: 2];
        wbs_we_o  = w_busy && wbm_we_i[w_sel];
        wbs_cyc_o = w_busy && w_gcyc;
        wbs_stb_o = w_busy && w_gstb && !w_tmo;
    end

    // responses go only to the granted master
    always_comb begin
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_busy && (r_idx == IW'(i))) begin
                wbm_ack_o[i] = wbs_ack_i;
                wbm_err_o[i] = wbs_err_i | w_tmo;
                wbm_rty_o[i] = wbs_rty_i;
            end
        end
    end

    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign grant_o   = r_grant;
    assign timeout_o = w_tmo;

endmodule

// File: tb/tb_wb_mem_rr_arbiter.sv
// Directed bench for wb_mem_rr_arbiter, two masters, TIMEOUT=16.
module tb_wb_mem_rr_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][AW-1:0] m_adr;
    logic [N-1:0][DW-1:0] m_dat;
    logic [N-1:0][3:0]    m_sel;
    logic [N-1:0]         m_we, m_cyc, m_stb;
    logic [N-1:0][2:0]    m_cti;
    logic [N-1:0][1:0]    m_bte;
    logic [DW*N-1:0]      m_dat_o;
    logic [N-1:0]         m_ack, m_err, m_rty;
    logic [AW-1:0]        s_adr;
    logic [DW-1:0]        s_dat_o, s_dat_i;
    logic [3:0]           s_sel;
    logic                 s_we, s_cyc, s_stb;
    logic [2:0]           s_cti;
    logic [1:0]           s_bte;
    logic                 s_ack, s_err, s_rty;
    logic [N-1:0]         gnt;
    logic                 tmo;

    wb_mem_rr_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(gnt), .timeout_o(tmo)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // one reset cycle; returns in the first cycle after reset with inputs idle
    task automatic do_reset();
        nxt();
        rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 0; s_err = 0; s_rty = 0;
        nxt();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  cyc;
        logic        ack, err, rty;
        logic [1:0]  e_gnt;
        logic        e_cyc, e_stb, e_we;
        logic [31:0] e_adr;
        logic [1:0]  e_ack, e_err, e_rty;
    } vec_t;

    vec_t tbl [9];
    int   ack0, ack1, early;

    initial begin
        m_adr = {A1, A0};
        m_dat = {32'hBBBB_0001, 32'hAAAA_0000};
        m_sel = {4'h3, 4'hF};
        m_we  = 2'b01;
        m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0;
        s_dat_i = 32'hCAFE_F00D;
        s_ack = 0; s_err = 0; s_rty = 0;

        //           cyc   ack err rty  gnt   cyc stb we adr  ack    err    rty
        tbl[0] = '{2'b11, 0, 0, 0, 2'b00, 0, 0, 0, A0, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{2'b11, 1, 0, 0, 2'b01, 1, 1, 1, A0, 2'b01, 2'b00, 2'b00};
        tbl[2] = '{2'b10, 0, 0, 0, 2'b01, 0, 0, 1, A0, 2'b00, 2'b00, 2'b00};
        tbl[3] = '{2'b10, 0, 0, 0, 2'b00, 0, 0, 0, A0, 2'b00, 2'b00, 2'b00};
        tbl[4] = '{2'b10, 1, 0, 0, 2'b10, 1, 1, 0, A1, 2'b10, 2'b00, 2'b00};
        tbl[5] = '{2'b11, 0, 0, 1, 2'b10, 1, 1, 0, A1, 2'b00, 2'b00, 2'b10};
        tbl[6] = '{2'b01, 0, 0, 0, 2'b10, 0, 0, 0, A1, 2'b00, 2'b00, 2'b00};
        tbl[7] = '{2'b01, 1, 0, 0, 2'b00, 0, 0, 0, A0, 2'b00, 2'b00, 2'b00};
        tbl[8] = '{2'b01, 0, 1, 0, 2'b01, 1, 1, 1, A0, 2'b00, 2'b01, 2'b00};

        // reset state
        rst = 1'b1;
        do_reset();
        #3;
        chk("rst_grant", 32'(gnt), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_scyc", 32'(s_cyc), 0);
        chk("rst_sstb", 32'(s_stb), 0);
        chk("rst_swe", 32'(s_we), 0);

        // table: arbitration, muxing, response routing
        for (int i = 0; i < 9; i++) begin
            nxt();
            m_cyc = tbl[i].cyc; m_stb = tbl[i].cyc;
            s_ack = tbl[i].ack; s_err = tbl[i].err; s_rty = tbl[i].rty;
            #3;
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_scyc", i), 32'(s_cyc), 32'(tbl[i].e_cyc));
            chk($sformatf("v%0d_sstb", i), 32'(s_stb), 32'(tbl[i].e_stb));
            chk($sformatf("v%0d_swe", i), 32'(s_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_sadr", i), s_adr, tbl[i].e_adr);
            chk($sformatf("v%0d_ack", i), 32'(m_ack), 32'(tbl[i].e_ack));
            chk($sformatf("v%0d_err", i), 32'(m_err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d_rty", i), 32'(m_rty), 32'(tbl[i].e_rty));
        end
        chk("dat_bcast", m_dat_o, {32'hCAFE_F00D, 32'hCAFE_F00D});

        // fairness: both masters request continuously, single beats
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        #3;
        chk("rr_idle", 32'(gnt), 0);
        for (int t = 0; t < 8; t++) begin
            logic [1:0] eg;
            eg = (t % 2 == 0) ? 2'b01 : 2'b10;
            nxt();
            s_ack = 1;
            #3;
            chk($sformatf("rr%0d_gnt", t), 32'(gnt), 32'(eg));
            chk($sformatf("rr%0d_ack", t), 32'(m_ack), 32'(eg));
            nxt();
            s_ack = 0; m_cyc = ~eg; m_stb = ~eg;
            nxt();
            m_cyc = 2'b11; m_stb = 2'b11;
        end

        // 8-beat burst from master 1 while master 0 waits
        do_reset();
        m_cyc = 2'b10; m_stb = 2'b10;
        #3;
        ack0 = 0; ack1 = 0;
        for (int b = 0; b < 8; b++) begin
            nxt();
            m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1;
            m_cti[1] = (b == 7) ? 3'b111 : 3'b010;
            #3;
            chk($sformatf("bst%0d_gnt", b), 32'(gnt), 32'h2);
            chk($sformatf("bst%0d_cti", b), 32'(s_cti), 32'(m_cti[1]));
            ack0 += int'(m_ack[0]);
            ack1 += int'(m_ack[1]);
        end
        nxt();
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 0; m_cti = '0;
        #3;
        chk("bst_ack1", 32'(ack1), 8);
        chk("bst_ack0", 32'(ack0), 0);
        chk("bst_drop_gnt", 32'(gnt), 32'h2);
        chk("bst_drop_scyc", 32'(s_cyc), 0);
        nxt(); #3;
        chk("bst_gap", 32'(gnt), 0);
        nxt(); #3;
        chk("bst_next", 32'(gnt), 32'h1);

        // watchdog: slave silent, fires on 17th stalled cycle
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        #3;
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            nxt(); #3;
            early += int'(tmo) + int'(m_err != 0) + int'(!s_stb);
        end
        chk("wd_early", 32'(early), 0);
        nxt(); #3;
        chk("wd_tmo", 32'(tmo), 1);
        chk("wd_err", 32'(m_err), 32'h1);
        chk("wd_sstb", 32'(s_stb), 0);
        chk("wd_gnt", 32'(gnt), 32'h1);
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            nxt(); #3;
            early += int'(tmo) + int'(m_err != 0) + int'(!s_stb);
        end
        chk("wd_early2", 32'(early), 0);
        // ack lands exactly on the timeout cycle
        nxt();
        s_ack = 1;
        #3;
        chk("wd_race_ack", 32'(m_ack), 32'h1);
        chk("wd_race_err", 32'(m_err), 0);
        chk("wd_race_tmo", 32'(tmo), 0);
        chk("wd_race_sstb", 32'(s_stb), 1);
        nxt();
        s_ack = 0;
        #3;
        chk("wd_after", 32'(tmo), 0);

        // reset pulse during master 0 burst beat 3
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_cti[0] = 3'b010;
        #3;
        nxt(); s_ack = 1;
        nxt();
        nxt(); rst = 1'b1;
        nxt();
        rst = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1;
        #3;
        chk("rmid_gnt", 32'(gnt), 0);
        chk("rmid_scyc", 32'(s_cyc), 0);
        chk("rmid_sstb", 32'(s_stb), 0);
        chk("rmid_ack", 32'(m_ack), 0);
        nxt(); #3;
        chk("rmid_first", 32'(gnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
